// File: rtl/cipherbox_pkg.sv
// Shared constants and types for the cipherbox command path.
// Holds the frame-assembler state encoding, error pulse bundle and UART timing defaults.
package cipherbox_pkg;

  localparam logic [7:0]  DEFAULT_SOF_BYTE   = 8'hA5;
  localparam int unsigned CLKS_PER_BIT       = 434;
  localparam int unsigned BITS_PER_BYTE      = 10;
  localparam int unsigned TIMEOUT_BYTE_TIMES = 2;
  localparam int unsigned DEFAULT_TIMEOUT_CLKS =
    TIMEOUT_BYTE_TIMES * BITS_PER_BYTE * CLKS_PER_BIT;

  typedef enum logic [2:0] {
    IDLE,
    OPCODE,
    PAYLOAD,
    CHECK,
    HOLD
  } frm_state_t;

  typedef struct packed {
    logic chk;
    logic timeout;
    logic ovr;
  } frm_err_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/uart_frame_assembler_if.sv
// Byte-strobe input and validated-frame output bundle of the frame assembler.
// The assembler side uses master; the UART/consumer environment uses slave.
interface uart_frame_assembler_if #(
  parameter int unsigned PAYLOAD_BYTES = 8
);

  logic                       rx_done;
  logic [7:0]                 rx_data;
  logic                       frm_valid;
  logic                       frm_ready;
  logic [7:0]                 frm_opcode;
  logic [8*PAYLOAD_BYTES-1:0] frm_payload;
  logic                       err_chk;
  logic                       err_timeout;
  logic                       err_ovr;

  modport master (
    input  rx_done,
    input  rx_data,
    input  frm_ready,
    output frm_valid,
    output frm_opcode,
    output frm_payload,
    output err_chk,
    output err_timeout,
    output err_ovr
  );

  modport slave (
    output rx_done,
    output rx_data,
    output frm_ready,
    input  frm_valid,
    input  frm_opcode,
    input  frm_payload,
    input  err_chk,
    input  err_timeout,
    input  err_ovr
  );

endinterface

// File: rtl/uart_frame_assembler_gap_timer.sv
// Inter-byte gap counter: clears on request, counts while enabled and flags
// the terminal count combinationally so the FSM can act on the same edge.
module uart_frame_assembler_gap_timer
  import cipherbox_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_c
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tc_c = enable_i && (cnt_q == TERMINAL);

  // Saturates at the terminal count; the FSM leaves the timed states on tc anyway.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && !tc_c) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// Turns uart_rx byte strobes into checksummed command frames (SOF, opcode,
// payload, XOR) presented on a valid/ready port, with single-cycle error pulses.
module uart_frame_assembler
  import cipherbox_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES = 8,
  parameter int unsigned TIMEOUT_CLKS  = DEFAULT_TIMEOUT_CLKS,
  parameter logic [7:0]  SOF_BYTE      = DEFAULT_SOF_BYTE
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_frame_assembler_if.master bus
);

  localparam int unsigned PAYLOAD_W = 8 * PAYLOAD_BYTES;
  localparam int unsigned BCNT_W    = cnt_width(PAYLOAD_BYTES);
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(PAYLOAD_BYTES - 1);

  frm_state_t           state_q;
  logic [7:0]           opcode_q;
  logic [7:0]           xor_q;
  logic [PAYLOAD_W-1:0] payload_q;
  logic [BCNT_W-1:0]    bcnt_q;
  logic                 valid_q;
  logic [7:0]           frm_opcode_q;
  logic [PAYLOAD_W-1:0] frm_payload_q;
  frm_err_t             err_q;

  logic timer_active_c;
  logic timer_clear_c;
  logic timeout_c;

  // Gap timing only runs while a frame is being collected.
  assign timer_active_c = (state_q == OPCODE) || (state_q == PAYLOAD) || (state_q == CHECK);
  assign timer_clear_c  = bus.rx_done || !timer_active_c;

  uart_frame_assembler_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (timer_clear_c),
    .enable_i(timer_active_c),
    .tc_c    (timeout_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      opcode_q      <= '0;
      xor_q         <= '0;
      payload_q     <= '0;
      bcnt_q        <= '0;
      valid_q       <= 1'b0;
      frm_opcode_q  <= '0;
      frm_payload_q <= '0;
      err_q         <= '0;
    end else begin
      err_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (bus.rx_done && (bus.rx_data == SOF_BYTE)) begin
            state_q <= OPCODE;
          end
        end

        OPCODE: begin
          if (bus.rx_done) begin
            opcode_q <= bus.rx_data;
            xor_q    <= bus.rx_data;
            bcnt_q   <= '0;
            state_q  <= PAYLOAD;
          end else if (timeout_c) begin
            err_q.timeout <= 1'b1;
            state_q       <= IDLE;
          end
        end

        // First payload byte ends up in the most significant byte.
        PAYLOAD: begin
          if (bus.rx_done) begin
            payload_q <= (payload_q << 8) | PAYLOAD_W'(bus.rx_data);
            xor_q     <= xor_q ^ bus.rx_data;
            if (bcnt_q == LAST_BYTE) begin
              state_q <= CHECK;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end else if (timeout_c) begin
            err_q.timeout <= 1'b1;
            state_q       <= IDLE;
          end
        end

        CHECK: begin
          if (bus.rx_done) begin
            if (bus.rx_data == xor_q) begin
              frm_opcode_q  <= opcode_q;
              frm_payload_q <= payload_q;
              valid_q       <= 1'b1;
              state_q       <= HOLD;
            end else begin
              err_q.chk <= 1'b1;
              state_q   <= IDLE;
            end
          end else if (timeout_c) begin
            err_q.timeout <= 1'b1;
            state_q       <= IDLE;
          end
        end

        // A byte landing on the handshake edge is still an overrun.
        HOLD: begin
          if (bus.rx_done) begin
            err_q.ovr <= 1'b1;
          end
          if (valid_q && bus.frm_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.frm_valid   = valid_q;
  assign bus.frm_opcode  = frm_opcode_q;
  assign bus.frm_payload = frm_payload_q;
  assign bus.err_chk     = err_q.chk;
  assign bus.err_timeout = err_q.timeout;
  assign bus.err_ovr     = err_q.ovr;

endmodule

// File: doc/uart_frame_assembler.md
# uart_frame_assembler

Sits directly downstream of `uart_rx` and turns its byte strobes into validated command frames for the cipher core. Frame format on the wire: SOF byte `8'hA5`, one opcode byte, `PAYLOAD_BYTES` payload bytes, one XOR checksum byte. A valid frame is presented on a valid/ready interface. Checksum failures, inter-byte timeouts and overruns are flagged with single-cycle error pulses.

## Interface
Parameters:
- `PAYLOAD_BYTES`, 8: payload bytes per frame (≥1).
- `TIMEOUT_CLKS`, 8680: maximum clocks between bytes inside a frame. This is 2 byte-times at 434 clks/bit × 10 bits.
- `SOF_BYTE`, 8'hA5: start-of-frame marker.

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: reset, asynchronous, active-high.
- `rx_done`  in  1: single-cycle strobe from `uart_rx`; `rx_data` is valid in that cycle.
- `rx_data`  in  8: received byte.
- `frm_valid`  out  1: frame available.
- `frm_ready`  in  1: consumer accepts the frame.
- `frm_opcode`  out  8: opcode of the held frame.
- `frm_payload`  out  8*PAYLOAD_BYTES: payload of the held frame. The first received byte goes in the MSB byte.
- `err_chk`  out  1: pulse, checksum mismatch.
- `err_timeout`  out  1: pulse, inter-byte gap exceeded.
- `err_ovr`  out  1: pulse, byte dropped while a frame is held.

## Operation
- States: IDLE, OPCODE, PAYLOAD, CHECK, HOLD.
- IDLE:
  - `rx_done` with `rx_data==SOF_BYTE` → OPCODE.
  - Any other byte is discarded silently.
- OPCODE: `rx_done` → latch the opcode, set running XOR = opcode, clear the byte counter, go to PAYLOAD.
- PAYLOAD: each `rx_done` shifts the byte into the payload register (shift left by 8, insert at [7:0]) and XORs it into the running checksum.
  - The byte counter counts 0..PAYLOAD_BYTES-1.
  - After the last byte → CHECK.
- CHECK: on `rx_done`:
  - If `rx_data` equals the running XOR → HOLD.
  - Otherwise pulse `err_chk` → IDLE.
  - A SOF value received here is treated as checksum data, not as a resync.
- HOLD: `frm_valid=1`, and the outputs stay stable.
  - `frm_valid & frm_ready` at a rising edge → IDLE.
  - Any `rx_done` in HOLD pulses `err_ovr` and the byte is discarded. This includes the handshake cycle.
- Timeout:
  - In OPCODE, PAYLOAD and CHECK, a gap counter clears on every `rx_done` and on state entry from IDLE.
  - When the counter reaches TIMEOUT_CLKS-1 without a strobe, pulse `err_timeout` and go to IDLE.
  - If `rx_done` arrives in the same cycle as the terminal count, the byte wins and no timeout occurs.
  - The counter is held at 0 in IDLE and HOLD.
- SOF values inside OPCODE or PAYLOAD are ordinary data.
- Error pulses are mutually exclusive per cycle. Each is high for exactly one clock.

## Timing
- Reset values:
  - State IDLE.
  - `frm_valid=0`, `frm_opcode=0`, `frm_payload=0`.
  - All error outputs 0.
  - Counters 0.
- Reset is asserted asynchronously at any time, mid-frame or in HOLD. It abandons the frame with no error pulse.
- Latency:
  - `frm_valid` rises on the edge that samples the checksum `rx_done` cycle, i.e. it is visible the cycle after the strobe.
  - Error pulses likewise appear the cycle after the triggering event.
- `frm_valid` falls the cycle after the handshake edge. There is no back-to-back HOLD.
  - A SOF arriving in the first IDLE cycle after the handshake is accepted.
- All outputs are registered. There are no combinational paths from input to output.

## Structure
- Shared package `cipherbox_pkg`:
  - `SOF_BYTE` default constant.
  - Frame state enum `frm_state_t` (IDLE/OPCODE/PAYLOAD/CHECK/HOLD).
  - `CLKS_PER_BIT=434` constant, from which `TIMEOUT_CLKS` is derived.
- Optional sub-module `gap_timer`:
  - Inputs: clear, enable.
  - Output: terminal-count pulse.
  - Width `$clog2(TIMEOUT_CLKS)`.
- Everything else lives in one FSM plus datapath registers.

## Test plan
- Send A5,01,11,22,33,44,55,66,77,88,89 with `frm_ready` held 0, then assert it 5 cycles later:
  - `frm_valid=1`, `frm_opcode=01`, `frm_payload=64'h1122334455667788`.
  - The handshake is taken after the 5 cycles and `frm_valid` drops the next cycle.
- Same frame with checksum 8A → `err_chk` single pulse, `frm_valid` stays 0. A following correct frame is then accepted.
- Bytes 00,FF,A5,02 followed by silence → leading 00/FF ignored, `err_timeout` pulses 8680 clocks after the 02 strobe, state returns to IDLE.
- Full frame held (`frm_ready=0`), then byte 5A strobed → `err_ovr` pulse, held frame unchanged.
- Payload containing A5 (opcode 03, payload A5×8, checksum 03) → frame accepted with `frm_payload=64'hA5A5A5A5A5A5A5A5`.
- Assert `rst` asynchronously after the 4th payload byte → outputs go to 0 immediately. A fresh full frame afterwards is accepted correctly.
